// File: rtl/stopwatch_pkg.sv
// Shared types, ASCII constants and BCD helpers for the lap stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    // mm:ss:cc held as six BCD nibbles, most significant first.
    typedef struct packed {
        logic [3:0] mm_t;
        logic [3:0] mm_u;
        logic [3:0] ss_t;
        logic [3:0] ss_u;
        logic [3:0] cc_t;
        logic [3:0] cc_u;
    } bcd_time_t;

    // Character at position 0..7 of the "mm:ss:cc" rendering of t.
    function automatic logic [7:0] bcd_time_to_char(input bcd_time_t t, input logic [2:0] pos);
        logic [7:0] c;
        case (pos)
            3'd0:    c = ASCII_ZERO + {4'h0, t.mm_t};
            3'd1:    c = ASCII_ZERO + {4'h0, t.mm_u};
            3'd2:    c = ASCII_COLON;
            3'd3:    c = ASCII_ZERO + {4'h0, t.ss_t};
            3'd4:    c = ASCII_ZERO + {4'h0, t.ss_u};
            3'd5:    c = ASCII_COLON;
            3'd6:    c = ASCII_ZERO + {4'h0, t.cc_t};
            default: c = ASCII_ZERO + {4'h0, t.cc_u};
        endcase
        return c;
    endfunction

    // One centisecond step with ripple carry; minutes wrap after max_t/max_u.
    function automatic bcd_time_t bcd_time_inc(input bcd_time_t t, input logic [3:0] max_t,
                                               input logic [3:0] max_u);
        bcd_time_t r;
        r = t;
        if (t.cc_u != 4'd9) begin
            r.cc_u = t.cc_u + 4'd1;
        end else begin
            r.cc_u = 4'd0;
            if (t.cc_t != 4'd9) begin
                r.cc_t = t.cc_t + 4'd1;
            end else begin
                r.cc_t = 4'd0;
                if (t.ss_u != 4'd9) begin
                    r.ss_u = t.ss_u + 4'd1;
                end else begin
                    r.ss_u = 4'd0;
                    if (t.ss_t != 4'd5) begin
                        r.ss_t = t.ss_t + 4'd1;
                    end else begin
                        r.ss_t = 4'd0;
                        if (t.mm_t == max_t && t.mm_u == max_u) begin
                            r.mm_t = 4'd0;
                            r.mm_u = 4'd0;
                        end else if (t.mm_u != 4'd9) begin
                            r.mm_u = t.mm_u + 4'd1;
                        end else begin
                            r.mm_u = 4'd0;
                            r.mm_t = t.mm_t + 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts clock cycles while enabled and pulses tick at terminal count.
module tick_gen #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] TERM = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise advance only while enabled (hold when not).
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick_o = en_i && (cnt_q == TERM);

endmodule

// File: rtl/stopwatch_lap.sv
// Run/pause/clear stopwatch with circular lap buffer and LCD character renderer.
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 100,
    parameter int LAP_DEPTH = 4,
    parameter int MIN_MAX   = 59,
    localparam int SEL_W    = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1,
    localparam int CNT_W    = $clog2(LAP_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sw_in,
    input  logic [SEL_W-1:0] lap_sel,
    input  logic [4:0]       index,
    output logic [7:0]       out,
    output logic             running,
    output logic [CNT_W-1:0] lap_count
);
    localparam logic [3:0] MAX_T = 4'(MIN_MAX / 10);
    localparam logic [3:0] MAX_U = 4'(MIN_MAX % 10);

    // Handshake-free design: buttons are level inputs, events are one-cycle rising edges.
    sw_state_e        state_q, state_d;
    logic [1:0]       sw_q;
    logic             start_ev, lap_ev, do_lap, do_clear, tick;
    bcd_time_t        time_q, time_d, sel_time;
    bcd_time_t        laps_q [LAP_DEPTH];
    logic [SEL_W-1:0] wr_ptr_q, wr_ptr_d, rd_idx;
    logic [CNT_W-1:0] lap_count_q, lap_count_d;
    logic [31:0]      rd_sum;
    logic             lap_valid;
    logic [2:0]       pos1, pos2;
    logic [7:0]       char_d, out_q;

    // Button history; reset high so a button held through reset must be re-pressed.
    always_ff @(posedge clk) begin
        if (rst) sw_q <= 2'b11;
        else     sw_q <= sw_in;
    end

    assign start_ev = sw_in[0] & ~sw_q[0];
    assign lap_ev   = sw_in[1] & ~sw_q[1];

    // FSM next state; a start event masks a simultaneous lap event.
    always_comb begin
        state_d  = state_q;
        do_lap   = 1'b0;
        do_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ev) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (start_ev)    state_d = ST_PAUSE;
                else if (lap_ev) do_lap = 1'b1;
            end
            ST_PAUSE: begin
                if (start_ev) begin
                    state_d = ST_RUN;
                end else if (lap_ev) begin
                    do_clear = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    tick_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q == ST_RUN),
        .clr_i ((state_q == ST_IDLE) || do_clear),
        .tick_o(tick)
    );

    // Time, write pointer and lap count next values.
    always_comb begin
        time_d      = time_q;
        wr_ptr_d    = wr_ptr_q;
        lap_count_d = lap_count_q;
        if (do_clear) begin
            time_d      = '0;
            wr_ptr_d    = '0;
            lap_count_d = '0;
        end else begin
            if (tick) time_d = bcd_time_inc(time_q, MAX_T, MAX_U);
            if (do_lap) begin
                wr_ptr_d = (wr_ptr_q == SEL_W'(LAP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
                if (lap_count_q != CNT_W'(LAP_DEPTH)) lap_count_d = lap_count_q + 1'b1;
            end
        end
    end

    // Time and lap bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            time_q      <= '0;
            wr_ptr_q    <= '0;
            lap_count_q <= '0;
        end else begin
            time_q      <= time_d;
            wr_ptr_q    <= wr_ptr_d;
            lap_count_q <= lap_count_d;
        end
    end

    // Lap storage captures the pre-tick time; entries are only meaningful below lap_count.
    always_ff @(posedge clk) begin
        if (do_lap) laps_q[wr_ptr_q] <= time_q;
    end

    // Character for the requested LCD index; lap_sel 0 is the most recent capture.
    always_comb begin
        rd_sum    = 32'(wr_ptr_q) + 32'(2 * LAP_DEPTH - 1) - 32'(lap_sel);
        rd_idx    = SEL_W'(rd_sum % 32'(LAP_DEPTH));
        sel_time  = laps_q[rd_idx];
        lap_valid = 32'(lap_sel) < 32'(lap_count_q);
        pos1      = index[2:0] - 3'd6;
        pos2      = index[2:0] - 3'd5;
        char_d    = ASCII_SPACE;
        if (!index[4]) begin
            case (index[3:0])
                4'd0: char_d = 8'h4C;
                4'd1: char_d = 8'h41;
                4'd2: char_d = 8'h50;
                4'd4: char_d = ASCII_ZERO + 8'(lap_sel);
                4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13: begin
                    if (lap_valid)                     char_d = bcd_time_to_char(sel_time, pos1);
                    else if (pos1 == 3'd2 || pos1 == 3'd5) char_d = ASCII_COLON;
                    else                               char_d = ASCII_DASH;
                end
                default: char_d = ASCII_SPACE;
            endcase
        end else begin
            case (index[3:0])
                4'd0: char_d = 8'h54;
                4'd1: char_d = 8'h49;
                4'd2: char_d = 8'h4D;
                4'd3: char_d = 8'h45;
                4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12:
                    char_d = bcd_time_to_char(time_q, pos2);
                4'd14: char_d = (state_q == ST_RUN) ? 8'h52 : (state_q == ST_PAUSE) ? 8'h50 : 8'h49;
                4'd15: char_d = (state_q == ST_RUN) ? 8'h4E : (state_q == ST_PAUSE) ? 8'h53 : 8'h44;
                default: char_d = ASCII_SPACE;
            endcase
        end
    end

    // Registered character output, one cycle behind index.
    always_ff @(posedge clk) begin
        if (rst) out_q <= 8'h00;
        else     out_q <= char_d;
    end

    assign out       = out_q;
    assign running   = (state_q == ST_RUN);
    assign lap_count = lap_count_q;

endmodule

// File: doc/stopwatch_lap.md
Name: stopwatch_lap

Overview:
Parametrised stopwatch for the 16x2 character LCD path, successor to the fixed 100 Hz stopwatch.
- Adds a run/pause/clear state machine driven by button edges.
- Adds a circular lap buffer of configurable depth.
- Renders ASCII characters for LCD line 1 (selected lap) and line 2 (live time) at the character index requested by the LCD controller.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
TICK_HZ, 100, count resolution in Hz (centisecond display); CLK_HZ must be an integer multiple of TICK_HZ
LAP_DEPTH, 4, number of stored laps (1..9)
MIN_MAX, 59, highest minute value before wrap (1..99)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sw_in  in  2  debounced buttons, level, active-high: [0] start/stop, [1] lap/clear
lap_sel  in  max(1,$clog2(LAP_DEPTH))  lap shown on line 1; 0 = newest
index  in  5  LCD character index: 0-15 line 1, 16-31 line 2
out  out  8  ASCII character for index
running  out  1  high in RUN state
lap_count  out  $clog2(LAP_DEPTH+1)  number of valid laps, saturating at LAP_DEPTH

Behaviour:
Reset (sync, active-high):
- state=IDLE, time=00:00:00, lap_count=0, out=8'h00, running=0, prescaler=0.
- Button history registers reset to 2'b11, so a button held through reset fires no event until it is released and pressed again.

Button events:
- An event is a rising edge of a sw_in bit (previous-cycle register), one cycle wide.

FSM (IDLE, RUN, PAUSE):
- IDLE: start -> RUN; lap -> ignored.
- RUN: start -> PAUSE; lap -> capture lap, stay in RUN.
- PAUSE: start -> RUN; lap -> clear (time=0, lap_count=0, prescaler=0) -> IDLE.
- Start and lap events in the same cycle: start wins, lap is discarded.

Timebase:
- Prescaler counts 0..CLK_HZ/TICK_HZ-1 only in RUN. It emits a 1-cycle tick at the terminal count, then returns to 0.
- Prescaler holds its value in PAUSE and is cleared in IDLE.
- The first tick after IDLE->RUN occurs CLK_HZ/TICK_HZ cycles after the start-event cycle.

Counting:
- Time is kept directly as BCD digit pairs: cc 00-99, ss 00-59, mm 00-MIN_MAX.
- A tick increments cc, carrying into ss and then mm.
- MIN_MAX:59:99 plus one tick -> 00:00:00. The block stays in RUN.

Lap capture:
- Stores the pre-tick time register value from the capture cycle; a tick in the same cycle does not affect the stored value.
- Buffer is circular with write pointer wrap. When full, the newest lap overwrites the oldest and lap_count stays at LAP_DEPTH.

Display:
- out is registered: out reflects the index from the previous cycle (1-cycle latency).
- Line 1:
  - 0-3 "LAP "; 4 = '0'+lap_sel; 5 ' '; 6-13 "mm:ss:cc" of selected lap; 14-15 spaces.
  - If lap_sel >= lap_count, positions 6-13 show "--:--:--".
- Line 2:
  - 0-3 "TIME"; 4 ' '; 5-12 "mm:ss:cc" live; 13 ' '; 14-15 "ID"/"RN"/"PS" by state.
- ASCII digit = 8'h30 + BCD nibble.

Decomposition:
- stopwatch_pkg holds:
  - state enum (IDLE/RUN/PAUSE)
  - ASCII constants (space, colon, dash, digit base)
  - packed BCD time type (six 4-bit nibbles)
  - function bcd_time_to_char(time, pos)
- Sub-module tick_gen: prescaler with enable, clear, and tick output; parameters CLK_HZ and TICK_HZ.

Test Plan:
Bench settings unless stated: CLK_HZ=1000, TICK_HZ=100 (10-cycle tick), LAP_DEPTH=2.
1. Reset, then sweep index 16-31 -> "TIME 00:00:00 ID"; out=8'h00 while rst=1; running=0.
2. Start press, wait 1000 cycles -> line 2 "00:01:00", running=1. Start press, wait 500 cycles -> still 00:01:00, "PS".
3. MIN_MAX=1, run to 01:59:99, one more tick -> 00:00:00 and state still RN.
4. Laps at 00:00:10, 00:00:20 and 00:00:30 -> lap_count=2. lap_sel=0 shows "00:00:30", lap_sel=1 shows "00:00:20".
5. Pause, then lap press -> time 00:00:00, lap_count=0, "ID". Line 1 positions 6-13 show "--:--:--".
6. Start and lap rise in the same cycle during RUN -> PAUSE with no lap captured. sw_in[0] held high across reset release -> remains IDLE.
